// File: rtl/cond_flag_unit_pkg.sv
// Shared types for the condition/flag unit: condition codes, branch types,
// NZCV bit positions and FSM states.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, HS = 4'b0010, LO = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_B     = 2'b01,
    BR_BCOND = 2'b10,
    BR_CBZ   = 2'b11
  } br_type_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } fsm_e;

endpackage

// File: rtl/cond_flag_unit_if.sv
// Bundle of EX-stage flag-write, ID-stage branch-request and decision signals.
interface cond_flag_unit_if #(
  parameter int COND_W = 4,
  parameter int BRT_W  = 2
);
  logic              ex_valid;
  logic              ex_set_flags;
  logic              ex_flush;
  logic              alu_negative;
  logic              alu_zero;
  logic              alu_carry;
  logic              alu_overflow;
  logic              id_valid;
  logic [BRT_W-1:0]  id_br_type;
  logic [COND_W-1:0] id_cond;
  logic              id_cbz_zero;
  logic [3:0]        flags_q;
  logic              br_resolved;
  logic              br_taken;
  logic              hazard_stall;

  modport slave (
    input  ex_valid, ex_set_flags, ex_flush,
    input  alu_negative, alu_zero, alu_carry, alu_overflow,
    input  id_valid, id_br_type, id_cond, id_cbz_zero,
    output flags_q, br_resolved, br_taken, hazard_stall
  );

  modport master (
    output ex_valid, ex_set_flags, ex_flush,
    output alu_negative, alu_zero, alu_carry, alu_overflow,
    output id_valid, id_br_type, id_cond, id_cbz_zero,
    input  flags_q, br_resolved, br_taken, hazard_stall
  );
endinterface

// File: rtl/cond_flag_unit_cond_eval.sv
// Combinational ARM condition-code evaluation against a 4-bit {N,Z,C,V} vector.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] flags_i,
  input  cond_e      cond_i,
  output logic       pass_o
);
  logic n, z, c, v;

  always_comb begin
    n = flags_i[FLAG_N];
    z = flags_i[FLAG_Z];
    c = flags_i[FLAG_C];
    v = flags_i[FLAG_V];
    pass_o = 1'b0;
    unique case (cond_i)
      EQ: pass_o = z;
      NE: pass_o = !z;
      HS: pass_o = c;
      LO: pass_o = !c;
      MI: pass_o = n;
      PL: pass_o = !n;
      VS: pass_o = v;
      VC: pass_o = !v;
      HI: pass_o = c && !z;
      LS: pass_o = !c || z;
      GE: pass_o = (n == v);
      LT: pass_o = (n != v);
      GT: pass_o = !z && (n == v);
      LE: pass_o = z || (n != v);
      AL: pass_o = 1'b1;
      NV: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_flag_unit.sv
// NZCV register plus registered B/B.cond/CBZ resolution.
// Optional macro FLAG_FWD_EN: forward live ALU flags instead of stalling one cycle.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int COND_W = 4,
  parameter int BRT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  cond_flag_unit_if.slave   bus
);
  logic [3:0] nzcv_q, nzcv_d;
  logic       resolved_q, resolved_d;
  logic       taken_q, taken_d;
  logic [3:0] alu_flags;
  logic [3:0] eval_flags;
  logic       flag_wr, is_bcond, req, hazard, accept, pass;
  br_type_e   br_type;

  assign alu_flags = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
  assign flag_wr   = bus.ex_valid && bus.ex_set_flags && !bus.ex_flush;
  assign br_type   = br_type_e'(bus.id_br_type);
  assign req       = bus.id_valid && (br_type != BR_NONE);
  assign is_bcond  = bus.id_valid && (br_type == BR_BCOND);
  assign hazard    = is_bcond && flag_wr;
  assign nzcv_d    = flag_wr ? alu_flags : nzcv_q;

`ifdef FLAG_FWD_EN
  assign eval_flags       = hazard ? alu_flags : nzcv_q;
  assign accept           = req;
  assign bus.hazard_stall = 1'b0;
`else
  fsm_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hazard) state_d = S_WAIT;
      S_WAIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // WAIT accepts the held request even if another flag write lands that cycle.
  always_comb begin
    bus.hazard_stall = (state_q == S_IDLE) && hazard;
    accept           = req && !bus.hazard_stall;
  end

  assign eval_flags = nzcv_q;
`endif

  cond_eval u_cond_eval (
    .flags_i (eval_flags),
    .cond_i  (cond_e'(bus.id_cond)),
    .pass_o  (pass)
  );

  always_comb begin
    resolved_d = accept;
    taken_d    = 1'b0;
    if (accept) begin
      unique case (br_type)
        BR_B:     taken_d = 1'b1;
        BR_BCOND: taken_d = pass;
        BR_CBZ:   taken_d = bus.id_cbz_zero;
        default:  taken_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv_q     <= '0;
      resolved_q <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      nzcv_q     <= nzcv_d;
      resolved_q <= resolved_d;
      taken_q    <= taken_d;
    end
  end

  assign bus.flags_q     = nzcv_q;
  assign bus.br_resolved = resolved_q;
  assign bus.br_taken    = taken_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed self-checking bench for cond_flag_unit (both FLAG_FWD_EN builds).
module tb_cond_flag_unit;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  cond_flag_unit_if #(.COND_W(4), .BRT_W(2)) bus ();

  cond_flag_unit #(.COND_W(4), .BRT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_write(input logic n, input logic z, input logic c, input logic v, input logic fl);
    bus.ex_valid = 1'b1; bus.ex_set_flags = 1'b1; bus.ex_flush = fl;
    bus.alu_negative = n; bus.alu_zero = z; bus.alu_carry = c; bus.alu_overflow = v;
  endtask

  task automatic ex_idle();
    bus.ex_valid = 1'b0; bus.ex_set_flags = 1'b0; bus.ex_flush = 1'b0;
    bus.alu_negative = 1'b0; bus.alu_zero = 1'b0; bus.alu_carry = 1'b0; bus.alu_overflow = 1'b0;
  endtask

  task automatic id_req(input logic vld, input logic [1:0] t, input logic [3:0] c, input logic cz);
    bus.id_valid = vld; bus.id_br_type = t; bus.id_cond = c; bus.id_cbz_zero = cz;
  endtask

  task automatic id_idle();
    id_req(1'b0, 2'b00, 4'b0000, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    ex_idle();
    id_idle();
    #1;
    chk("rst_flags", bus.flags_q, 4'b0000);
    chk("rst_res", {3'b0, bus.br_resolved}, 4'd0);
    chk("rst_taken", {3'b0, bus.br_taken}, 4'd0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("idle_res", {3'b0, bus.br_resolved}, 4'd0);

    // B.cond EQ on reset flags: not taken
    id_req(1'b1, 2'b10, 4'b0000, 1'b0);
    #1 chk("eq0_stall", {3'b0, bus.hazard_stall}, 4'd0);
    cyc();
    chk("eq0_res", {3'b0, bus.br_resolved}, 4'd1);
    chk("eq0_taken", {3'b0, bus.br_taken}, 4'd0);
    id_idle();
    cyc();
    chk("pulse_res", {3'b0, bus.br_resolved}, 4'd0);

    // SUBS sets N=1, V=0
    ex_write(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    ex_idle();
    chk("subs_flags", bus.flags_q, 4'b1000);

    id_req(1'b1, 2'b10, 4'b1011, 1'b0);
    cyc();
    chk("lt_res", {3'b0, bus.br_resolved}, 4'd1);
    chk("lt_taken", {3'b0, bus.br_taken}, 4'd1);
    id_req(1'b1, 2'b10, 4'b1010, 1'b0);
    cyc();
    chk("ge_res", {3'b0, bus.br_resolved}, 4'd1);
    chk("ge_taken", {3'b0, bus.br_taken}, 4'd0);
    id_idle();

    // Flushed flag write alongside B.cond EQ: no write, no stall, old Z used
    ex_write(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    id_req(1'b1, 2'b10, 4'b0000, 1'b0);
    #1 chk("flush_stall", {3'b0, bus.hazard_stall}, 4'd0);
    cyc();
    chk("flush_flags", bus.flags_q, 4'b1000);
    chk("flush_res", {3'b0, bus.br_resolved}, 4'd1);
    chk("flush_taken", {3'b0, bus.br_taken}, 4'd0);
    ex_idle();
    id_idle();
    cyc();

    // Hazard: B.cond NE with a write setting Z=1
    ex_write(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    id_req(1'b1, 2'b10, 4'b0001, 1'b0);
`ifdef FLAG_FWD_EN
    #1 chk("haz_stall", {3'b0, bus.hazard_stall}, 4'd0);
    cyc();
    ex_idle();
    chk("haz_flags", bus.flags_q, 4'b0100);
    chk("haz_res", {3'b0, bus.br_resolved}, 4'd1);
    chk("haz_taken", {3'b0, bus.br_taken}, 4'd0);
    id_idle();
`else
    #1 chk("haz_stall", {3'b0, bus.hazard_stall}, 4'd1);
    cyc();
    ex_idle();
    #1;
    chk("haz_flags", bus.flags_q, 4'b0100);
    chk("haz_wait_res", {3'b0, bus.br_resolved}, 4'd0);
    chk("haz_wait_stall", {3'b0, bus.hazard_stall}, 4'd0);
    cyc();
    chk("haz_res", {3'b0, bus.br_resolved}, 4'd1);
    chk("haz_taken", {3'b0, bus.br_taken}, 4'd0);
    id_idle();
    cyc();
    chk("haz_pulse", {3'b0, bus.br_resolved}, 4'd0);
`endif

    // B with cond NE while Z=1: still taken
    id_req(1'b1, 2'b01, 4'b0001, 1'b0);
    cyc();
    chk("b_res", {3'b0, bus.br_resolved}, 4'd1);
    chk("b_taken", {3'b0, bus.br_taken}, 4'd1);

    // CBZ during a flag write (C=1): no stall
    ex_write(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    id_req(1'b1, 2'b11, 4'b0000, 1'b1);
    #1 chk("cbz_stall", {3'b0, bus.hazard_stall}, 4'd0);
    cyc();
    ex_idle();
    chk("cbz_res", {3'b0, bus.br_resolved}, 4'd1);
    chk("cbz_taken", {3'b0, bus.br_taken}, 4'd1);
    chk("cbz_flags", bus.flags_q, 4'b0010);

    // flags 0010: HI taken, LE not, CBZ nonzero not taken
    id_req(1'b1, 2'b10, 4'b1000, 1'b0);
    cyc();
    chk("hi_taken", {3'b0, bus.br_taken}, 4'd1);
    id_req(1'b1, 2'b10, 4'b1101, 1'b0);
    cyc();
    chk("le_res", {3'b0, bus.br_resolved}, 4'd1);
    chk("le_taken", {3'b0, bus.br_taken}, 4'd0);
    id_req(1'b1, 2'b11, 4'b0000, 1'b0);
    cyc();
    chk("cbznz_res", {3'b0, bus.br_resolved}, 4'd1);
    chk("cbznz_taken", {3'b0, bus.br_taken}, 4'd0);
    id_req(1'b1, 2'b00, 4'b1110, 1'b1);
    cyc();
    chk("none_res", {3'b0, bus.br_resolved}, 4'd0);
    id_req(1'b0, 2'b01, 4'b1110, 1'b1);
    cyc();
    chk("novld_res", {3'b0, bus.br_resolved}, 4'd0);
    chk("novld_taken", {3'b0, bus.br_taken}, 4'd0);

    // Reset while a hazard is pending
    ex_write(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    id_req(1'b1, 2'b10, 4'b0000, 1'b0);
    cyc();
    reset = 1'b1;
    ex_idle();
    id_idle();
    #1;
    chk("rstw_flags", bus.flags_q, 4'b0000);
    chk("rstw_res", {3'b0, bus.br_resolved}, 4'd0);
    cyc();
    chk("rstw_res2", {3'b0, bus.br_resolved}, 4'd0);
    reset = 1'b0;
    cyc();
    chk("rstw_res3", {3'b0, bus.br_resolved}, 4'd0);

    // FSM back in IDLE: a fresh hazard behaves normally
    ex_write(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    id_req(1'b1, 2'b10, 4'b0001, 1'b0);
`ifdef FLAG_FWD_EN
    #1 chk("post_stall", {3'b0, bus.hazard_stall}, 4'd0);
    cyc();
    ex_idle();
    id_idle();
`else
    #1 chk("post_stall", {3'b0, bus.hazard_stall}, 4'd1);
    cyc();
    ex_idle();
    cyc();
    id_idle();
`endif
    chk("post_res", {3'b0, bus.br_resolved}, 4'd1);
    chk("post_taken", {3'b0, bus.br_taken}, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
